parser_arbiter: RTL and testbench
=================================

Name: parser_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single `parser` instance between two AXI-Stream RX sources, e.g. two MAC/DMA ingress paths.
- Locks the grant for a whole packet, converts `tkeep` to a byte count, and drives the parser's `data_buffer`/`idx`/`last_flag` interface through one output register stage.
- Honours `parser_ready` backpressure.
- Keeps per-port packet counters for status registers.

Parameters:
- DATA_WIDTH, 64, beat width in bits; must be a multiple of 8.
- KEEP_W, DATA_WIDTH/8, tkeep width (derived, not overridden).
- IDX_W, $clog2(DATA_WIDTH/8+1), width of the idx byte count (4 at default).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s0_tdata  in  DATA_WIDTH  port 0 beat data
- s0_tkeep  in  KEEP_W  port 0 byte enables (contiguous, LSB-aligned)
- s0_tlast  in  1  port 0 end of packet
- s0_tvalid  in  1  port 0 beat valid
- s0_tready  out  1  port 0 beat accepted when tvalid&tready
- s1_tdata/s1_tkeep/s1_tlast/s1_tvalid/s1_tready  as port 0, for port 1
- data_buffer  out  DATA_WIDTH  beat to parser
- idx  out  IDX_W  valid byte count of data_buffer; 0 = no beat
- last_flag  out  1  beat is last of packet
- parser_ready  in  1  parser consumes current beat this cycle
- grant_id  out  1  port currently owning the parser
- busy  out  1  a packet is in progress
- drop_last  out  1  one-cycle pulse: a zero-tkeep tlast beat was discarded
- pkt_cnt0  out  16  packets completed from port 0, wraps at 0xFFFF->0
- pkt_cnt1  out  16  packets completed from port 1, wraps

Behaviour:
- Reset (asynchronous, rst_n low):
  - data_buffer=0, idx=0, last_flag=0, s*_tready=0.
  - grant_id=0, busy=0, drop_last=0, pkt_cnt*=0.
  - Internal last_served=1, so port 0 wins the first tie.
- Reset mid-packet: the in-flight packet is abandoned and the output beat is cleared. No partial-packet recovery. After release, the arbiter restarts in IDLE.
- FSM states: IDLE, BUSY.
- IDLE:
  - s*_tready=0.
  - If exactly one s*_tvalid is high, grant that port.
  - If both are high, grant the port != last_served.
  - On a grant: grant_id<=port, busy<=1, go to BUSY. Arbitration costs 1 cycle.
  - If no tvalid, stay in IDLE.
- BUSY:
  - s<grant>_tready = (idx==0) | parser_ready. The non-granted tready is 0.
  - Accepted beat with tkeep!=0:
    - next cycle data_buffer<=tdata, idx<=popcount(tkeep), last_flag<=tlast.
    - Latency is 1 cycle.
  - Accepted beat with tkeep==0 and tlast=0: discarded, no output change.
  - Accepted beat with tkeep==0 and tlast=1: discarded, drop_last pulses 1 cycle, and the packet counts as ended.
  - Accepted beat with tlast=1:
    - pkt_cnt<grant> += 1 (wrap).
    - last_served<=grant, busy<=0, next state IDLE.
    - The other port may win on the following cycle, giving a 1-cycle bubble per packet.
- Output register:
  - A beat is consumed when idx!=0 & parser_ready.
  - On consume with no new beat loaded the same cycle, idx<=0, last_flag<=0, data_buffer<=0.
  - Consume and load in the same cycle: the new beat replaces the old one, giving full throughput of one beat per cycle.
  - While idx!=0 & !parser_ready, data_buffer/idx/last_flag hold stable and the granted tready=0.
- tkeep is required contiguous from LSB. A non-contiguous tkeep still yields idx=popcount. No error is flagged; this is not a verified case.
- A non-granted port's tvalid is ignored, and the source must hold its beat (AXI-S rules).
- grant_id holds its last value while IDLE.

Test Plan:
- Port 0 only, 3-beat packet, tkeep FF/FF/0F, parser_ready=1:
  - grant cycle, then idx=8,8,4 on consecutive cycles, last_flag=1 only on the third.
  - pkt_cnt0=1, busy returns to 0.
- Both ports tvalid from reset, each sending 2-beat packets:
  - order port0, port1, port0, port1; grant_id toggles; 1 idle cycle between packets.
  - pkt_cnt0=pkt_cnt1=2.
- Port 1 packet of 4 beats with parser_ready low for 3 cycles on beat 2:
  - beat 2 holds data/idx stable, s1_tready=0 during the stall.
  - No beat lost or duplicated; data sequence matches input exactly.
- Port 0 beats tkeep=01, 03, 7F, FF, tlast on the last beat: idx=1, 2, 7, 8.
- Port 0 packet ending with tkeep=00, tlast=1:
  - drop_last pulses once, no output beat for it, pkt_cnt0 increments.
  - Arbiter returns to IDLE.
- rst_n asserted mid-packet (beat 2 of 5, asynchronous to clk):
  - all outputs 0 immediately.
  - After release, a new port-1 packet is granted and counted with pkt_cnt1=1, pkt_cnt0=0.

Source files
------------

// File: rtl/parser_arbiter.sv
// parser_arbiter: packet-granular round-robin arbiter sharing one parser between two AXI-Stream sources
module parser_arbiter #(
    parameter int DATA_WIDTH = 64,
    localparam int KEEP_W = DATA_WIDTH / 8,
    localparam int IDX_W = $clog2(DATA_WIDTH / 8 + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s0_tdata,
    input  logic [KEEP_W-1:0]     s0_tkeep,
    input  logic                  s0_tlast,
    input  logic                  s0_tvalid,
    output logic                  s0_tready,
    input  logic [DATA_WIDTH-1:0] s1_tdata,
    input  logic [KEEP_W-1:0]     s1_tkeep,
    input  logic                  s1_tlast,
    input  logic                  s1_tvalid,
    output logic                  s1_tready,
    output logic [DATA_WIDTH-1:0] data_buffer,
    output logic [IDX_W-1:0]      idx,
    output logic                  last_flag,
    input  logic                  parser_ready,
    output logic                  grant_id,
    output logic                  busy,
    output logic                  drop_last,
    output logic [15:0]           pkt_cnt0,
    output logic [15:0]           pkt_cnt1
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_nx;
    logic last_served;
    logic [DATA_WIDTH-1:0] g_data;
    logic [KEEP_W-1:0] g_keep;
    logic [IDX_W-1:0] g_cnt;
    logic g_last, g_valid, g_ready, acc, load, consume, any_valid, pick;

    always_comb begin
        g_data = grant_id ? s1_tdata : s0_tdata;
        g_keep = grant_id ? s1_tkeep : s0_tkeep;
        g_last = grant_id ? s1_tlast : s0_tlast;
        g_valid = grant_id ? s1_tvalid : s0_tvalid;
        // the output register can take a new beat when empty or being drained this cycle
        g_ready = state == BUSY && (idx == '0 || parser_ready);
        acc = g_ready && g_valid;
        load = acc && |g_keep;
        consume = idx != '0 && parser_ready;
        any_valid = s0_tvalid || s1_tvalid;
        pick = (s0_tvalid && s1_tvalid) ? !last_served : s1_tvalid;
        g_cnt = '0;
        for (int i = 0; i < KEEP_W; i++) g_cnt = g_cnt + IDX_W'(g_keep[i]);
        state_nx = state == IDLE ? (any_valid ? BUSY : IDLE) : ((acc && g_last) ? IDLE : BUSY);
    end

    assign s0_tready = g_ready && !grant_id;
    assign s1_tready = g_ready && grant_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_buffer <= '0;
            idx <= '0;
            last_flag <= 1'b0;
            grant_id <= 1'b0;
            busy <= 1'b0;
            drop_last <= 1'b0;
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
            last_served <= 1'b1;
        end else begin
            drop_last <= acc && !(|g_keep) && g_last;
            if (load) begin
                data_buffer <= g_data;
                idx <= g_cnt;
                last_flag <= g_last;
            end else if (consume) begin
                data_buffer <= '0;
                idx <= '0;
                last_flag <= 1'b0;
            end
            if (state == IDLE && any_valid) begin
                grant_id <= pick;
                busy <= 1'b1;
            end
            if (acc && g_last) begin
                busy <= 1'b0;
                last_served <= grant_id;
                if (grant_id) pkt_cnt1 <= pkt_cnt1 + 16'd1;
                else pkt_cnt0 <= pkt_cnt0 + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_parser_arbiter.sv
// tb_parser_arbiter: directed and randomized checks of parser_arbiter against a per-port beat scoreboard
module tb_parser_arbiter;
    typedef struct packed {logic [63:0] data; logic [7:0] keep; logic last;} beat_t;
    typedef struct packed {logic [63:0] data; logic [3:0] idx; logic last;} exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [63:0] tdata [2];
    logic [7:0] tkeep [2];
    logic [1:0] tlast, tvalid, tready;
    logic [63:0] data_buffer;
    logic [3:0] idx;
    logic last_flag, parser_ready, grant_id, busy, drop_last;
    logic [15:0] pkt_cnt0, pkt_cnt1;

    beat_t src [2][512];
    exp_t exp_b [2][512];
    int src_n [2], src_rd [2], exp_n [2], exp_rd [2], exp_pkt [2];
    int exp_drop, drop_seen, n_chk, n_pass, cyc, pr_mode, low_run, mp;
    bit mon_en, busy_prev, stall_prev;
    logic [63:0] prev_data;
    logic [4:0] prev_il;
    int cons_cyc [$], cons_idx [$], glog [$], low_runs [$];

    always #5 clk = ~clk;

    parser_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .s0_tdata(tdata[0]), .s0_tkeep(tkeep[0]), .s0_tlast(tlast[0]), .s0_tvalid(tvalid[0]), .s0_tready(tready[0]),
        .s1_tdata(tdata[1]), .s1_tkeep(tkeep[1]), .s1_tlast(tlast[1]), .s1_tvalid(tvalid[1]), .s1_tready(tready[1]),
        .data_buffer(data_buffer), .idx(idx), .last_flag(last_flag), .parser_ready(parser_ready),
        .grant_id(grant_id), .busy(busy), .drop_last(drop_last), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    task automatic add_beat(input int p, input logic [7:0] keep, input logic last);
        beat_t b;
        b.data = {$urandom, $urandom};
        b.data[63] = 1'(p);
        b.keep = keep;
        b.last = last;
        src[p][src_n[p]] = b;
        src_n[p]++;
        if (keep != 8'h00) begin
            exp_b[p][exp_n[p]] = '{data: b.data, idx: 4'($countones(keep)), last: last};
            exp_n[p]++;
        end
        if (last) begin
            exp_pkt[p]++;
            if (keep == 8'h00) exp_drop++;
        end
    endtask

    task automatic add_rand_pkt(input int p);
        int len, n;
        len = $urandom_range(1, 5);
        for (int i = 0; i < len; i++) begin
            n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
            add_beat(p, 8'((16'd1 << n) - 16'd1), i == len - 1);
        end
    endtask

    task automatic drive(input int p, input int gap);
        int t;
        bit hs;
        beat_t b;
        while (src_rd[p] < src_n[p]) begin
            b = src[p][src_rd[p]];
            if (gap > 0 && $urandom_range(0, 99) < gap) begin
                tvalid[p] = 1'b0;
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
            tdata[p] = b.data;
            tkeep[p] = b.keep;
            tlast[p] = b.last;
            tvalid[p] = 1'b1;
            t = 0;
            hs = 1'b0;
            while (!hs && t < 300) begin
                @(negedge clk);
                hs = tready[p];
                @(posedge clk); #1;
                t++;
            end
            if (!hs) begin
                check("handshake_timeout", 64'd0, 64'd1);
                tvalid[p] = 1'b0;
                return;
            end
            src_rd[p]++;
        end
        tvalid[p] = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((idx != 4'd0 || busy) && t < 500) begin @(posedge clk); #1; t++; end
        check("drain_timeout", 64'({idx != 4'd0, busy}), 64'd0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_pkt = '{0, 0};
        exp_drop = 0;
        drop_seen = 0;
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        cons_cyc.delete();
        cons_idx.delete();
        glog.delete();
        low_runs.delete();
        low_run = 0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (pr_mode == 1) begin #1; parser_ready = $urandom_range(0, 99) < 70; end

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (idx != 4'd0 && parser_ready) begin
                mp = int'(data_buffer[63]);
                if (exp_rd[mp] < exp_n[mp]) begin
                    check("beat_data", data_buffer, exp_b[mp][exp_rd[mp]].data);
                    check("beat_idx", 64'(idx), 64'(exp_b[mp][exp_rd[mp]].idx));
                    check("beat_last", 64'(last_flag), 64'(exp_b[mp][exp_rd[mp]].last));
                    exp_rd[mp]++;
                end else check("extra_beat", 64'd1, 64'd0);
                cons_cyc.push_back(cyc);
                cons_idx.push_back(int'(idx));
            end
            if (stall_prev) begin
                check("stall_data", data_buffer, prev_data);
                check("stall_idx_last", 64'({idx, last_flag}), 64'(prev_il));
            end
            stall_prev = idx != 4'd0 && !parser_ready;
            prev_data = data_buffer;
            prev_il = {idx, last_flag};
            if (drop_last) drop_seen++;
            if (!busy) low_run++;
            else if (!busy_prev) begin
                glog.push_back(int'(grant_id));
                low_runs.push_back(low_run);
                low_run = 0;
            end
            busy_prev = busy;
        end else begin
            stall_prev = 1'b0;
            busy_prev = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int start, base, t;
        tvalid = 2'b00;
        tlast = 2'b00;
        tdata = '{64'd0, 64'd0};
        tkeep = '{8'd0, 8'd0};
        parser_ready = 1'b1;
        pr_mode = 0;
        mon_en = 1'b1;
        src_n = '{0, 0}; src_rd = '{0, 0}; exp_n = '{0, 0}; exp_rd = '{0, 0}; exp_pkt = '{0, 0};
        exp_drop = 0; drop_seen = 0; n_chk = 0; n_pass = 0; cyc = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_data", data_buffer, 64'd0);
        check("rst_idx_last", 64'({idx, last_flag}), 64'd0);
        check("rst_tready", 64'(tready), 64'd0);
        check("rst_grant_busy_drop", 64'({grant_id, busy, drop_last}), 64'd0);
        check("rst_cnts", 64'({pkt_cnt0, pkt_cnt1}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // single port, FF/FF/0F: grant cycle then one beat per cycle
        clear_logs();
        add_beat(0, 8'hFF, 1'b0); add_beat(0, 8'hFF, 1'b0); add_beat(0, 8'h0F, 1'b1);
        start = cyc;
        drive(0, 0);
        drain();
        check("p1_beats", 64'(cons_cyc.size()), 64'd3);
        if (cons_cyc.size() == 3) begin
            check("p1_latency", 64'(cons_cyc[0] - start), 64'd2);
            check("p1_back_to_back", 64'(cons_cyc[2] - cons_cyc[0]), 64'd2);
            check("p1_idx_seq", 64'({cons_idx[0][3:0], cons_idx[1][3:0], cons_idx[2][3:0]}), 64'h884);
        end
        check("p1_cnt0", 64'(pkt_cnt0), 64'(exp_pkt[0]));
        check("p1_busy", 64'(busy), 64'd0);

        // both ports contending from reset: strict alternation with a one-cycle bubble
        do_reset();
        clear_logs();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++) begin add_beat(p, 8'hFF, 1'b0); add_beat(p, 8'hFF, 1'b1); end
        fork drive(0, 0); drive(1, 0); join
        drain();
        check("rr_grants", 64'(glog.size()), 64'd4);
        if (glog.size() == 4) check("rr_order", 64'({glog[0][0], glog[1][0], glog[2][0], glog[3][0]}), 64'b0101);
        if (low_runs.size() == 4) check("rr_bubbles", 64'({low_runs[1][3:0], low_runs[2][3:0], low_runs[3][3:0]}), 64'h111);
        check("rr_cnts", 64'({pkt_cnt0, pkt_cnt1}), 64'({16'(exp_pkt[0]), 16'(exp_pkt[1])}));

        // port 1 with a three-cycle parser stall on beat 2
        base = src_n[1];
        add_beat(1, 8'hFF, 1'b0); add_beat(1, 8'hFF, 1'b0); add_beat(1, 8'hFF, 1'b0); add_beat(1, 8'h3F, 1'b1);
        fork
            drive(1, 0);
            begin
                t = 0;
                while (!(idx != 4'd0 && data_buffer == src[1][base].data) && t < 100) begin @(negedge clk); t++; end
                check("stall_wait_timeout", 64'(t < 100), 64'd1);
                @(posedge clk); #1;
                parser_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_tready1", 64'(tready[1]), 64'd0);
                    check("stall_beat2", data_buffer, src[1][base + 1].data);
                    @(posedge clk); #1;
                end
                parser_ready = 1'b1;
            end
        join
        drain();
        check("stall_cnt1", 64'(pkt_cnt1), 64'(exp_pkt[1]));

        // tkeep to byte count
        clear_logs();
        add_beat(0, 8'h01, 1'b0); add_beat(0, 8'h03, 1'b0); add_beat(0, 8'h7F, 1'b0); add_beat(0, 8'hFF, 1'b1);
        drive(0, 0);
        drain();
        check("keep_beats", 64'(cons_idx.size()), 64'd4);
        if (cons_idx.size() == 4) check("keep_idx_seq", 64'({cons_idx[0][3:0], cons_idx[1][3:0], cons_idx[2][3:0], cons_idx[3][3:0]}), 64'h1278);

        // packet ending with an empty tlast beat
        clear_logs();
        drop_seen = 0;
        add_beat(0, 8'hFF, 1'b0); add_beat(0, 8'h00, 1'b1);
        drive(0, 0);
        drain();
        check("drop_pulses", 64'(drop_seen), 64'd1);
        check("drop_beats", 64'(cons_idx.size()), 64'd1);
        check("drop_cnt0", 64'(pkt_cnt0), 64'(exp_pkt[0]));
        check("drop_idle", 64'(busy), 64'd0);
        drop_seen = 1;
        exp_drop = 1;

        // randomized traffic with random backpressure
        for (int k = 0; k < 25; k++) begin add_rand_pkt(0); add_rand_pkt(1); end
        pr_mode = 1;
        fork drive(0, 30); drive(1, 30); join
        pr_mode = 0;
        @(posedge clk); #2;
        parser_ready = 1'b1;
        drain();
        check("rand_cnt0", 64'(pkt_cnt0), 64'(exp_pkt[0]));
        check("rand_cnt1", 64'(pkt_cnt1), 64'(exp_pkt[1]));
        check("rand_drops", 64'(drop_seen), 64'(exp_drop));
        check("rand_all_p0", 64'(exp_rd[0]), 64'(exp_n[0]));
        check("rand_all_p1", 64'(exp_rd[1]), 64'(exp_n[1]));

        // asynchronous reset in the middle of a port 0 packet
        mon_en = 1'b0;
        tdata[0] = 64'h0123_4567_89AB_CDEF;
        tkeep[0] = 8'hFF;
        tlast[0] = 1'b0;
        tvalid[0] = 1'b1;
        begin
            int n = 0;
            t = 0;
            while (n < 2 && t < 50) begin
                @(negedge clk);
                if (tready[0]) n++;
                @(posedge clk); #1;
                t++;
            end
            check("mid_pkt_accepts", 64'(n), 64'd2);
        end
        #2 rst_n = 1'b0;
        #1;
        check("async_data", data_buffer, 64'd0);
        check("async_idx_last", 64'({idx, last_flag}), 64'd0);
        check("async_tready", 64'(tready), 64'd0);
        check("async_grant_busy_drop", 64'({grant_id, busy, drop_last}), 64'd0);
        check("async_cnts", 64'({pkt_cnt0, pkt_cnt1}), 64'd0);
        tvalid[0] = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        exp_pkt = '{0, 0};
        clear_logs();
        mon_en = 1'b1;
        @(posedge clk); #1;
        add_beat(1, 8'hFF, 1'b0); add_beat(1, 8'hFF, 1'b0); add_beat(1, 8'h07, 1'b1);
        drive(1, 0);
        drain();
        check("post_rst_cnt1", 64'(pkt_cnt1), 64'd1);
        check("post_rst_cnt0", 64'(pkt_cnt0), 64'd0);
        check("post_rst_grant", 64'(glog.size() == 1 && glog[0] == 1), 64'd1);
        check("post_rst_all_p1", 64'(exp_rd[1]), 64'(exp_n[1]));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
